// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit 7-segment display.
//   Slot timing comes from a cycle counter on clk_in (no derived clocks).
//   Each digit slot is DIV = CLK_HZ/REFRESH_HZ cycles long: BLANK_CYCLES with
//   all anodes off (anti-ghosting gap), then the remainder driving one anode.
//   Display data is double-buffered: load captures into a pending buffer,
//   which is copied to the active buffer at the end of the last digit slot.
//
// Ports
//   clk_in      in   system clock
//   reset       in   asynchronous, active-high reset
//   digits_in   in   hex nibble per digit, digit k = [4k+3:4k]
//   dp_in       in   decimal point per digit, 1 = lit
//   digit_en    in   1 = digit displayed, 0 = kept dark
//   load        in   1-cycle strobe, captures the three inputs above
//   bright      in   (SEG_DIM_EN only) 4-bit brightness, sampled at BLANK->DRIVE
//   anode       out  active-low digit select (at most one low)
//   cathode     out  active-low segments {g,f,e,d,c,b,a}
//   dp_n        out  active-low decimal point
//   frame_done  out  1-cycle pulse on the last DRIVE cycle of the last digit
//
// Build option
//   SEG_DIM_EN  adds the bright input; the anode is held low only for the first
//               ((bright+1)*(DIV-BLANK_CYCLES))/16 cycles of each DRIVE phase.
//
// Assumes 1 <= BLANK_CYCLES < DIV.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | all anodes off; cathode/dp_n already show the new digit
// ST_DRIVE | anode of the current digit low (if enabled / within dim time)

module seg_scan_ctrl #(
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 480,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
`ifdef SEG_DIM_EN
  input  logic [3:0]              bright,
`endif
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int DIV          = CLK_HZ / REFRESH_HZ;
  localparam int DRIVE_CYCLES = DIV - BLANK_CYCLES;
  localparam int CW           = $clog2(DIV + 1);
  localparam int IW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] FD_PRE     = CW'(DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t                  state;
  logic [CW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;

  logic [4*NUM_DIGITS-1:0] pend_dig, act_dig;
  logic [NUM_DIGITS-1:0]   pend_dp,  act_dp;
  logic [NUM_DIGITS-1:0]   pend_en,  act_en;

  logic                    frame_end;
  logic [4*NUM_DIGITS-1:0] pend_dig_nx, act_dig_nx;
  logic [NUM_DIGITS-1:0]   pend_dp_nx,  act_dp_nx;
  logic [NUM_DIGITS-1:0]   pend_en_nx,  act_en_nx;
  logic [IW-1:0]           idx_nx;
  logic [3:0]              nib_nx;
  logic                    dp_nx;
  logic [NUM_DIGITS-1:0]   sel_n;

`ifdef SEG_DIM_EN
  logic [CW-1:0]           on_len;
  logic [CW-1:0]           on_len_nx;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // The cathode for the next slot is decoded from the buffer contents as they
  // will be after this edge, so a load on the frame_done cycle shows up in
  // the very next slot 0.
  always_comb begin
    frame_end   = (state == ST_DRIVE) && (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);
    pend_dig_nx = load ? digits_in : pend_dig;
    pend_dp_nx  = load ? dp_in     : pend_dp;
    pend_en_nx  = load ? digit_en  : pend_en;
    act_dig_nx  = frame_end ? pend_dig_nx : act_dig;
    act_dp_nx   = frame_end ? pend_dp_nx  : act_dp;
    act_en_nx   = frame_end ? pend_en_nx  : act_en;
    idx_nx      = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    nib_nx      = act_dig_nx[{idx_nx, 2'b00} +: 4];
    dp_nx       = act_dp_nx[idx_nx];
    sel_n       = ~(NUM_DIGITS'(1) << idx);
  end

`ifdef SEG_DIM_EN
  always_comb begin
    on_len_nx = CW'(((int'(bright) + 1) * DRIVE_CYCLES) / 16);
  end
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= ST_BLANK;
      slot_cnt   <= '0;
      idx        <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      anode      <= '1;
      cathode    <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
`ifdef SEG_DIM_EN
      on_len     <= '0;
`endif
    end else begin
      pend_dig <= pend_dig_nx;
      pend_dp  <= pend_dp_nx;
      pend_en  <= pend_en_nx;
      act_dig  <= act_dig_nx;
      act_dp   <= act_dp_nx;
      act_en   <= act_en_nx;

      // High during the cycle whose count is SLOT_LAST on the last digit;
      // in BLANK this only matches when DRIVE is a single cycle long.
      frame_done <= (idx == IDX_LAST) && (slot_cnt == FD_PRE);

      case (state)
        ST_BLANK: begin
          anode    <= '1;
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST) begin
            state <= ST_DRIVE;
`ifdef SEG_DIM_EN
            on_len <= on_len_nx;
            anode  <= (act_en[idx] && (on_len_nx != '0)) ? sel_n : '1;
`else
            anode  <= act_en[idx] ? sel_n : '1;
`endif
          end
        end
        ST_DRIVE: begin
          if (slot_cnt == SLOT_LAST) begin
            state    <= ST_BLANK;
            slot_cnt <= '0;
            idx      <= idx_nx;
            anode    <= '1;
            cathode  <= seg_decode(nib_nx);
            dp_n     <= ~dp_nx;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
`ifdef SEG_DIM_EN
            // Next cycle's DRIVE position is past the lit window: go dark.
            if ((int'(slot_cnt) + 1 - BLANK_CYCLES) >= int'(on_len))
              anode <= '1;
`endif
          end
        end
        default: begin
          state    <= ST_BLANK;
          slot_cnt <= '0;
          anode    <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (CLK_HZ=1600, REFRESH_HZ=100, NUM_DIGITS=4,
// BLANK_CYCLES=2 -> 16-cycle slots, 64-cycle frames). The stimulus process
// pushes one expected record per digit slot; the monitor accumulates what the
// DUT shows over each slot and compares at the slot's last cycle.
module tb_seg_scan_ctrl;

  localparam int SLOT = 16;
  localparam int NDIG = 4;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in     = '0;
  logic [3:0]  digit_en  = '0;
  logic        load      = 1'b0;
`ifdef SEG_DIM_EN
  logic [3:0]  bright    = 4'd15;
`endif
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_n;
  logic        frame_done;

  seg_scan_ctrl #(
    .CLK_HZ(1600), .REFRESH_HZ(100), .NUM_DIGITS(NDIG), .BLANK_CYCLES(2)
  ) dut (
    .clk_in(clk_in), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .load(load),
`ifdef SEG_DIM_EN
    .bright(bright),
`endif
    .anode(anode), .cathode(cathode), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] an;
    int         low;
    logic [6:0] cath;
    logic       dpn;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // ---------------- monitor ----------------
  int         k = 0;
  int         mon_slot = 0;
  int         m_low;
  logic [3:0] m_lowval;
  logic [6:0] m_cath0;
  logic       m_dp0;
  bit         m_blank_ok, m_multi, m_fd_bad, m_stable;

  always @(negedge clk_in) begin
    if (reset) begin
      k = 0;
    end else begin
      int p;
      p = k % SLOT;
      if (p == 0) begin
        m_low = 0; m_lowval = 4'hF; m_blank_ok = 1; m_multi = 0;
        m_fd_bad = 0; m_stable = 1; m_cath0 = cathode; m_dp0 = dp_n;
      end
      if (anode != 4'hF) begin
        m_low++;
        m_lowval = anode;
        if (p < 2) m_blank_ok = 0;
      end
      if ($countones(~anode) > 1) m_multi = 1;
      if (cathode !== m_cath0 || dp_n !== m_dp0) m_stable = 0;
      if (frame_done && p != SLOT - 1) m_fd_bad = 1;
      if (p == SLOT - 1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL slot%0d scoreboard: got no expected record, required one", mon_slot);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("slot%0d anode", mon_slot),         32'(m_lowval),   32'(e.an));
          chk($sformatf("slot%0d low_cycles", mon_slot),    32'(m_low),      32'(e.low));
          chk($sformatf("slot%0d cathode", mon_slot),       32'(m_cath0),    32'(e.cath));
          chk($sformatf("slot%0d dp_n", mon_slot),          32'(m_dp0),      32'(e.dpn));
          chk($sformatf("slot%0d frame_done", mon_slot),    32'(frame_done), 32'(e.fd));
          chk($sformatf("slot%0d fd_position", mon_slot),   32'(m_fd_bad),   32'(0));
          chk($sformatf("slot%0d blank_gap", mon_slot),     32'(m_blank_ok), 32'(1));
          chk($sformatf("slot%0d one_anode", mon_slot),     32'(m_multi),    32'(0));
          chk($sformatf("slot%0d seg_stable", mon_slot),    32'(m_stable),   32'(1));
        end
        mon_slot++;
      end
      k++;
    end
  end

  // ---------------- stimulus + reference model ----------------
  logic [15:0] m_pend_dig, m_act_dig;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_en, m_act_en;
  bit          first_slot;
  int          slot_no;

  task automatic model_reset();
    m_pend_dig = '0; m_act_dig = '0;
    m_pend_dp  = '0; m_act_dp  = '0;
    m_pend_en  = '0; m_act_en  = '0;
    first_slot = 1;
    slot_no    = 0;
  endtask

  // Runs one slot starting at posedge+1 of its cycle 0. ld_pos < 0: no load.
  // stop_at < SLOT runs a partial slot with no expectation pushed.
  task automatic run_slot(input int ld_pos, input logic [15:0] d, input logic [3:0] dp,
                          input logic [3:0] en, input logic [3:0] br, input int stop_at);
    int   idx;
    exp_t e;
    idx = slot_no % NDIG;
`ifdef SEG_DIM_EN
    bright = br;
`endif
    if (stop_at == SLOT) begin
      e.low  = m_act_en[idx] ? ((int'(br) + 1) * 14) / 16 : 0;
      e.an   = (e.low > 0) ? ~(4'b0001 << idx) : 4'hF;
      e.cath = first_slot ? 7'h7F : dec(m_act_dig[idx*4 +: 4]);
      e.dpn  = first_slot ? 1'b1 : ~m_act_dp[idx];
      e.fd   = (idx == NDIG - 1);
      exp_q.push_back(e);
    end
    for (int p = 0; p < stop_at; p++) begin
      if (p == ld_pos) begin
        load = 1'b1; digits_in = d; dp_in = dp; digit_en = en;
        m_pend_dig = d; m_pend_dp = dp; m_pend_en = en;
      end else begin
        load = 1'b0;
      end
      @(posedge clk_in); #1;
    end
    load = 1'b0;
    if (stop_at == SLOT) begin
      if (idx == NDIG - 1) begin
        m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
      end
      first_slot = 0;
      slot_no++;
    end
  endtask

  task automatic idle_slot(input logic [3:0] br);
    run_slot(-1, 16'h0, 4'h0, 4'h0, br, SLOT);
  endtask

  task automatic idle_frame(input logic [3:0] br);
    for (int s = 0; s < NDIG; s++) idle_slot(br);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset anode",      32'(anode),      32'(4'hF));
    chk("reset cathode",    32'(cathode),    32'(7'h7F));
    chk("reset dp_n",       32'(dp_n),       32'(1));
    chk("reset frame_done", 32'(frame_done), 32'(0));
    reset = 1'b0;

    // Frame A: dark (nothing active yet); load 3210, all enabled.
    run_slot(5, 16'h3210, 4'h0, 4'hF, 4'd15, SLOT);
    idle_slot(4'd15); idle_slot(4'd15); idle_slot(4'd15);
    // Frame B: 3210 on all digits; queue digit_en = 1010.
    idle_slot(4'd15);
    run_slot(3, 16'h3210, 4'h0, 4'b1010, 4'd15, SLOT);
    idle_slot(4'd15); idle_slot(4'd15);
    // Frame C: slots 0/2 dark; mid-frame load FFFF must not show until frame D.
    idle_slot(4'd15);
    run_slot(8, 16'hFFFF, 4'h0, 4'hF, 4'd15, SLOT);
    idle_slot(4'd15); idle_slot(4'd15);
    // Frame D: all F; two loads, the later one wins.
    idle_slot(4'd15);
    run_slot(2, 16'h9876, 4'h0, 4'hF, 4'd15, SLOT);
    run_slot(10, 16'hBCDE, 4'b0100, 4'hF, 4'd15, SLOT);
    idle_slot(4'd15);
    // Frame E: BCDE with dp on digit 2; load on the frame_done cycle.
    idle_slot(4'd15); idle_slot(4'd15); idle_slot(4'd15);
    run_slot(15, 16'h4567, 4'b0001, 4'b0111, 4'd15, SLOT);
    // Frame F: 4567 straight away, digit 3 dark, dp on digit 0.
    idle_frame(4'd15);
    // Frame G: reset in the DRIVE phase of digit 2.
    idle_slot(4'd15); idle_slot(4'd15);
    run_slot(-1, 16'h0, 4'h0, 4'h0, 4'd15, 8);
    #2;
    chk("pre_reset anode", 32'(anode), 32'(4'b1011));
    reset = 1'b1;
    #1;
    chk("async_reset anode",      32'(anode),      32'(4'hF));
    chk("async_reset cathode",    32'(cathode),    32'(7'h7F));
    chk("async_reset dp_n",       32'(dp_n),       32'(1));
    chk("async_reset frame_done", 32'(frame_done), 32'(0));
    @(posedge clk_in); #1;
    reset = 1'b0;
    model_reset();
    // Frame H: dark after reset, reload 3210. Frame I: digit 0 back at 1110.
    run_slot(1, 16'h3210, 4'h0, 4'hF, 4'd15, SLOT);
    idle_slot(4'd15); idle_slot(4'd15); idle_slot(4'd15);
    idle_frame(4'd15);
`ifdef SEG_DIM_EN
    idle_frame(4'd3);
    idle_slot(4'd0); idle_slot(4'd8); idle_slot(4'd15); idle_slot(4'd3);
`endif

    for (int i = 0; i < 2 * SLOT && exp_q.size() != 0; i++) @(posedge clk_in);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
